// File: rtl/ball_hit_detector.sv
// Per-frame ball/object overlap detector: classifies overlap pixels into {L,T,R,B} sides and reports once per frame.
// Latency: report registered one cycle after startOfFrame; accumulators update on the cycle of each overlap pixel.
// Backpressure: level hit_valid held until hit_ack; a new publish overwrites an unacked report and sets sticky overrun.
module ball_hit_detector #(
    parameter int N_OBJ          = 4,
    parameter int BALL_W         = 64,
    parameter int BALL_H         = 64,
    parameter int EDGE           = 8,
    parameter int HOLDOFF_FRAMES = 2
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             startOfFrame,
    input  logic             ball_draw,
    input  logic [N_OBJ-1:0] obj_draw,
    input  logic [10:0]      ball_offset_x,
    input  logic [10:0]      ball_offset_y,
    input  logic             hit_ack,
    output logic             hit_valid,
    output logic [3:0]       hit_sides,
    output logic [N_OBJ-1:0] hit_obj,
    output logic [7:0]       hit_pixels,
    output logic             overrun
);

    // Offset thresholds at the offset port width so every compare is 11-bit.
    localparam logic [10:0] LP_W     = 11'(BALL_W);
    localparam logic [10:0] LP_H     = 11'(BALL_H);
    localparam logic [10:0] LP_EDGE  = 11'(EDGE);
    localparam logic [10:0] LP_RIGHT = 11'(BALL_W - EDGE);
    localparam logic [10:0] LP_BOT   = 11'(BALL_H - EDGE);

    // Hold-off counter sized for HOLDOFF_FRAMES, never narrower than one bit.
    localparam int              CNT_W      = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] LP_HOLD   = CNT_W'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
    localparam bit               LP_HOLD_EN = (HOLDOFF_FRAMES > 0);

    typedef enum logic {
        ST_ARMED   = 1'b0,
        ST_HOLDOFF = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_hold_nxt;

    logic [3:0]         r_acc_sides;
    logic [N_OBJ-1:0]   r_acc_obj;
    logic [7:0]         r_acc_pix;

    logic               w_in_box;
    logic               w_overlap;
    logic [3:0]         w_sides;
    logic               w_publish;
    logic               w_acc_en;

    // Pixels outside the ball box never count, even if both requests are high.
    assign w_in_box  = (ball_offset_x < LP_W) && (ball_offset_y < LP_H);
    assign w_overlap = ball_draw && (|obj_draw) && w_in_box;

    // Side bits in {L,T,R,B} order; corners light two bits, the centre none.
    assign w_sides = {(ball_offset_x <  LP_EDGE),
                      (ball_offset_y <  LP_EDGE),
                      (ball_offset_x >= LP_RIGHT),
                      (ball_offset_y >= LP_BOT)};

    // State register: arm/hold-off mode and remaining hold-off frames.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_ARMED;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next state: transitions happen only at frame boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        if (startOfFrame) begin
            case (r_state)
                ST_ARMED: begin
                    if (LP_HOLD_EN && (|r_acc_obj)) begin
                        w_state_nxt = ST_HOLDOFF;
                        w_hold_nxt  = LP_HOLD;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_hold_cnt == LP_ONE) begin
                        w_state_nxt = ST_ARMED;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt  = r_hold_cnt - LP_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARMED;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs of the FSM: publish strobe and accumulate enable. A pixel on the
    // startOfFrame cycle belongs to the new frame, so it is accepted only if the
    // frame being entered is an armed one.
    always_comb begin
        w_publish = startOfFrame && (r_state == ST_ARMED);
        w_acc_en  = w_overlap && (w_state_nxt == ST_ARMED);
    end

    // Frame accumulators: restart at each frame boundary, OR/saturate within a frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_acc_sides <= '0;
            r_acc_obj   <= '0;
            r_acc_pix   <= '0;
        end else if (startOfFrame) begin
            r_acc_sides <= w_acc_en ? w_sides  : 4'b0000;
            r_acc_obj   <= w_acc_en ? obj_draw : '0;
            r_acc_pix   <= w_acc_en ? 8'd1     : 8'd0;
        end else if (w_acc_en) begin
            r_acc_sides <= r_acc_sides | w_sides;
            r_acc_obj   <= r_acc_obj | obj_draw;
            r_acc_pix   <= (r_acc_pix == 8'hFF) ? r_acc_pix : r_acc_pix + 8'd1;
        end
    end

    // Report register and handshake: publish beats a same-cycle ack, overwrite of an unacked report is sticky-flagged.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit_valid  <= 1'b0;
            hit_sides  <= '0;
            hit_obj    <= '0;
            hit_pixels <= '0;
            overrun    <= 1'b0;
        end else if (w_publish) begin
            hit_valid  <= 1'b1;
            hit_sides  <= r_acc_sides;
            hit_obj    <= r_acc_obj;
            hit_pixels <= r_acc_pix;
            if (hit_valid && !hit_ack) begin
                overrun <= 1'b1;
            end
        end else if (hit_valid && hit_ack) begin
            hit_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/ball_hit_detector.md
Name: ball_hit_detector

Overview:
- Consumer side of the ball/object drawing-request interface. Watches per-pixel overlap between the ball drawing request and N object drawing requests during a frame.
- Classifies each overlap pixel into hit sides {Left, Top, Right, Bottom}, using the ball-local pixel offset, and accumulates the result over the frame.
- Publishes one hit report per frame at startOfFrame to the ball physics block, with a valid/ack handshake.
- Sits between the VGA object drawers and the ball movement logic. hit_sides uses the same 4-bit {L,T,R,B} encoding that indexes HIT_COLORS.

Parameters:
- N_OBJ, 4, number of object drawing-request inputs (spring, flippers, bumpers, walls).
- BALL_W, 64, ball bounding-box width in pixels (defines_ball::WIDTH).
- BALL_H, 64, ball bounding-box height in pixels (defines_ball::HEIGHT).
- EDGE, 8, edge band thickness in pixels used for side classification; legal range 1..BALL_W/2.
- HOLDOFF_FRAMES, 2, frames after a nonzero report during which new hits are ignored; 0 disables hold-off.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at frame start
- ball_draw  in  1  ball drawing request for the current pixel
- obj_draw  in  N_OBJ  object drawing requests for the current pixel
- ball_offset_x  in  11  pixel X offset inside the ball box, 0..BALL_W-1
- ball_offset_y  in  11  pixel Y offset inside the ball box, 0..BALL_H-1
- hit_ack  in  1  consumer accepts the current report
- hit_valid  out  1  a report is pending
- hit_sides  out  4  {L,T,R,B} of the report, bit3=Left .. bit0=Bottom
- hit_obj  out  N_OBJ  objects hit in the report
- hit_pixels  out  8  overlap pixel count of the report, saturating at 255
- overrun  out  1  sticky flag: a report was overwritten before it was acked

Behaviour:
- Reset (resetN=0, asynchronous):
  - All outputs go to 0.
  - Accumulators are cleared; the hold-off counter is 0; the state machine goes to ARMED.
  - Reset mid-frame discards any partial accumulation.
- Overlap pixel: the cycle where ball_draw=1 and |obj_draw=1.
- Side classification, combinational from the offsets:
  - L = x<EDGE; R = x>=BALL_W-EDGE; T = y<EDGE; B = y>=BALL_H-EDGE.
  - Corner pixels set two bits.
  - A centre pixel sets no side bit but still counts toward obj and pixels.
  - Offsets outside the box (x>=BALL_W or y>=BALL_H) are ignored entirely.
- Accumulators, registered and updated only in state ARMED:
  - acc_sides |= sides
  - acc_obj |= obj_draw (only when ball_draw=1)
  - acc_pix increments, saturating at 255.
- State machine, 2 states:
  - ARMED: accumulate.
  - HOLDOFF: accumulators stay cleared and overlap pixels are ignored.
  - Counter hold_cnt is decremented on each startOfFrame in HOLDOFF.
- At startOfFrame (single cycle, report registered 1 cycle later):
  - Publish: hit_sides<=acc_sides, hit_obj<=acc_obj, hit_pixels<=acc_pix, hit_valid<=1.
  - This happens every frame while ARMED, including all-zero reports.
  - In HOLDOFF no report is published.
  - Accumulators are cleared in the same edge.
  - If an overlap pixel coincides with startOfFrame, it goes into the fresh (new-frame) accumulator, not the published report.
  - If published acc_obj!=0 and HOLDOFF_FRAMES>0: go to HOLDOFF with hold_cnt=HOLDOFF_FRAMES.
  - In HOLDOFF: if hold_cnt==1, go to ARMED (the next frame accumulates); else hold_cnt-1.
- Handshake:
  - hit_valid is level; it clears the cycle after hit_ack=1 while hit_valid=1.
  - hit_ack while hit_valid=0 is ignored.
  - Report fields hold stable while hit_valid=1, except on overwrite.
  - Publish while hit_valid=1 and no ack this cycle: fields are overwritten, hit_valid stays 1, overrun<=1.
  - overrun is sticky until reset.
  - Publish and ack in the same cycle: publish wins, hit_valid stays 1, no overrun.
- Widths:
  - acc_pix is 8 bits, saturating, no wrap.
  - hold_cnt is $clog2(HOLDOFF_FRAMES+1) bits, minimum 1.

Test Plan:
1. Reset then idle frames, no draw, ack each report -> hit_valid=1 one cycle after each startOfFrame; hit_sides=0, hit_obj=0, hit_pixels=0; overrun=0.
2. One overlap pixel at x=2,y=30 with obj_draw=4'b0100, then startOfFrame -> hit_sides=4'b1000, hit_obj=4'b0100, hit_pixels=1; the next 2 frames publish nothing; the 3rd frame reports again.
3. Overlap at corner x=63,y=63 plus centre x=32,y=32, obj 0001 -> hit_sides=4'b0011, hit_pixels=2.
4. 300 overlap pixels in one frame -> hit_pixels=255 (saturated).
5. Nonzero report left un-acked with HOLDOFF_FRAMES=0 across the next startOfFrame -> fields updated, hit_valid=1, overrun=1 and sticky; a report where ack coincides with publish leaves overrun unchanged.
6. Overlap pixel coincident with startOfFrame -> excluded from the current report, present in the next. Additionally, resetN low mid-frame with pending accumulation -> all outputs 0 immediately; the next report is all-zero.
